// File: rtl/if_prefetch_queue.sv
// ============================================================================
// if_prefetch_queue
// ----------------------------------------------------------------------------
// Instruction prefetch unit feeding the IF/ID pipeline register.
//
// It owns the fetch PC and issues in-order 32-bit fetches to instruction
// memory. Returned words are buffered with their PCs in a DEPTH-entry FIFO.
// A branch redirect empties the FIFO. Responses that are still in flight at
// the time of the redirect are counted in 'discard' and dropped in the FLUSH
// state.
//
// Parameters
//   DEPTH     FIFO entries (power of 2, >= 2). Also caps the sum of queued
//             entries and outstanding requests.
//   RESET_PC  fetch PC loaded at reset.
//
// Ports
//   clk             clock, all state updates on the rising edge
//   reset           asynchronous, active-low reset
//   imem_req_valid  fetch request valid
//   imem_req_ready  instruction memory accepts the request
//   imem_req_addr   fetch address (4-byte aligned)
//   imem_rsp_valid  in-order response valid, no backpressure
//   imem_rsp_data   instruction word
//   redirect        branch taken, has priority over everything else
//   redirect_pc     branch target
//   stall           IF/ID does not consume this cycle
//   instr_valid     queue head valid
//   instr           head instruction (holds its last value when empty)
//   instr_pc        head instruction PC (holds its last value when empty)
//   occupancy       current FIFO entries
//
// Optional feature: define IFQ_PERF_EN to add 32-bit saturating counters
//   perf_stall_cycles, perf_empty_cycles and perf_redirects.
// ============================================================================
module if_prefetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [63:0] RESET_PC = 64'h0
) (
    input  logic                     clk,
    input  logic                     reset,
    output logic                     imem_req_valid,
    input  logic                     imem_req_ready,
    output logic [63:0]              imem_req_addr,
    input  logic                     imem_rsp_valid,
    input  logic [31:0]              imem_rsp_data,
    input  logic                     redirect,
    input  logic [63:0]              redirect_pc,
    input  logic                     stall,
    output logic                     instr_valid,
    output logic [31:0]              instr,
    output logic [63:0]              instr_pc,
    output logic [$clog2(DEPTH):0]   occupancy
`ifdef IFQ_PERF_EN
    ,
    output logic [31:0]              perf_stall_cycles,
    output logic [31:0]              perf_empty_cycles,
    output logic [31:0]              perf_redirects
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW:0]   DEPTH_SUM = (CW+1)'(DEPTH);
    localparam logic [CW-1:0] DEPTH_CNT = CW'(DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        FLUSH = 2'd2
    } state_t;

    state_t          state_reg, state_next;
    logic [63:0]     fetch_pc_reg, fetch_pc_next;
    logic [CW-1:0]   count_reg, count_next;
    logic [CW-1:0]   outstanding_reg, outstanding_next;
    logic [CW-1:0]   discard_reg, discard_next;
    logic [AW-1:0]   rd_ptr_reg, rd_ptr_next;
    logic [AW-1:0]   wr_ptr_reg, wr_ptr_next;
    logic [AW-1:0]   tag_rd_reg, tag_rd_next;
    logic [AW-1:0]   tag_wr_reg, tag_wr_next;
    logic [31:0]     head_data_reg, head_data_next;
    logic [63:0]     head_pc_reg, head_pc_next;
    logic            ovf_reg, ovf_next;

    // Storage: instruction/PC queue and the PC tags of in-flight requests.
    logic [31:0]     data_mem [DEPTH];
    logic [63:0]     pc_mem   [DEPTH];
    logic [63:0]     tag_mem  [DEPTH];

    logic            issue;
    logic            fire;
    logic            rsp_acc;
    logic            rsp_drop;
    logic            pop;
    logic            push;
    logic            push_ok;
    logic            ovf_set;
    logic            full;
    logic [CW:0]     inflight_sum;
    logic [CW-1:0]   outstanding_after;
    logic [CW-1:0]   discard_after;
    logic [63:0]     rsp_tag;

    // ------------------------------------------------------------------
    // Handshake and queue control
    // ------------------------------------------------------------------
    assign inflight_sum = {1'b0, count_reg} + {1'b0, outstanding_reg};
    assign full         = (count_reg == DEPTH_CNT);

    // Issue is capped so every outstanding request has a queue slot waiting.
    assign issue    = (state_reg == FETCH) && !redirect && (inflight_sum < DEPTH_SUM);
    assign fire     = issue && imem_req_ready;

    // Responses only count while something is actually outstanding; words
    // left over from before a reset are ignored.
    assign rsp_acc  = imem_rsp_valid && (state_reg == FETCH) && (outstanding_reg != '0);
    assign rsp_drop = imem_rsp_valid && (state_reg == FLUSH) && (discard_reg != '0);

    assign pop      = instr_valid && !stall && !redirect;
    assign push     = rsp_acc && !redirect;
    assign push_ok  = push && (!full || pop);
    assign ovf_set  = push && full && !pop;

    assign rsp_tag  = tag_mem[tag_rd_reg];

    // Bookkeeping after this cycle's issue and response are accounted for.
    assign outstanding_after = outstanding_reg + CW'(fire) - CW'(rsp_acc);
    assign discard_after     = discard_reg - CW'(rsp_drop);

    assign imem_req_valid = issue;
    assign imem_req_addr  = fetch_pc_reg;
    assign instr_valid    = (count_reg != '0);
    assign instr          = head_data_reg;
    assign instr_pc       = head_pc_reg;
    assign occupancy      = count_reg;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_next       = state_reg;
        fetch_pc_next    = fetch_pc_reg;
        count_next       = count_reg;
        outstanding_next = outstanding_reg;
        discard_next     = discard_reg;
        rd_ptr_next      = rd_ptr_reg;
        wr_ptr_next      = wr_ptr_reg;
        tag_rd_next      = tag_rd_reg;
        tag_wr_next      = tag_wr_reg;
        ovf_next         = ovf_reg;

        case (state_reg)
            IDLE:    state_next = FETCH;
            FETCH:   if (redirect && (outstanding_after != '0)) state_next = FLUSH;
            FLUSH:   if (discard_after == '0) state_next = FETCH;
            default: state_next = IDLE;
        endcase

        if (redirect) begin
            // Everything still in flight becomes garbage. No request is
            // issued this cycle, so nothing new joins the discard count.
            fetch_pc_next    = redirect_pc;
            count_next       = '0;
            rd_ptr_next      = '0;
            wr_ptr_next      = '0;
            tag_rd_next      = '0;
            tag_wr_next      = '0;
            outstanding_next = '0;
            discard_next     = (state_reg == FLUSH) ? discard_after : outstanding_after;
        end else begin
            if (fire) begin
                fetch_pc_next = fetch_pc_reg + 64'd4;
                tag_wr_next   = tag_wr_reg + AW'(1);
            end
            if (rsp_acc) begin
                tag_rd_next = tag_rd_reg + AW'(1);
            end
            outstanding_next = outstanding_after;
            if (state_reg == FLUSH) begin
                discard_next = discard_after;
            end
            if (push_ok) begin
                wr_ptr_next = wr_ptr_reg + AW'(1);
            end
            if (pop) begin
                rd_ptr_next = rd_ptr_reg + AW'(1);
            end
            count_next = count_reg + CW'(push_ok) - CW'(pop);
            if (ovf_set) begin
                ovf_next = 1'b1;
            end
        end
    end

    // Registered head: preload the entry that will be at the head next
    // cycle. When that entry is the one being written right now, bypass
    // the incoming response. With an empty result the head holds.
    always_comb begin
        head_data_next = head_data_reg;
        head_pc_next   = head_pc_reg;
        if (!redirect && (count_next != '0)) begin
            if (push_ok && (rd_ptr_next == wr_ptr_reg)) begin
                head_data_next = imem_rsp_data;
                head_pc_next   = rsp_tag;
            end else begin
                head_data_next = data_mem[rd_ptr_next];
                head_pc_next   = pc_mem[rd_ptr_next];
            end
        end
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg       <= IDLE;
            fetch_pc_reg    <= RESET_PC;
            count_reg       <= '0;
            outstanding_reg <= '0;
            discard_reg     <= '0;
            rd_ptr_reg      <= '0;
            wr_ptr_reg      <= '0;
            tag_rd_reg      <= '0;
            tag_wr_reg      <= '0;
            head_data_reg   <= '0;
            head_pc_reg     <= '0;
            ovf_reg         <= 1'b0;
        end else begin
            state_reg       <= state_next;
            fetch_pc_reg    <= fetch_pc_next;
            count_reg       <= count_next;
            outstanding_reg <= outstanding_next;
            discard_reg     <= discard_next;
            rd_ptr_reg      <= rd_ptr_next;
            wr_ptr_reg      <= wr_ptr_next;
            tag_rd_reg      <= tag_rd_next;
            tag_wr_reg      <= tag_wr_next;
            head_data_reg   <= head_data_next;
            head_pc_reg     <= head_pc_next;
            ovf_reg         <= ovf_next;
        end
    end

    // Storage arrays carry no reset; the pointers and counters define
    // which entries are meaningful.
    always_ff @(posedge clk) begin
        if (fire) begin
            tag_mem[tag_wr_reg] <= fetch_pc_reg;
        end
        if (push_ok) begin
            data_mem[wr_ptr_reg] <= imem_rsp_data;
            pc_mem[wr_ptr_reg]   <= rsp_tag;
        end
    end

`ifdef IFQ_PERF_EN
    // ------------------------------------------------------------------
    // Saturating performance counters
    // ------------------------------------------------------------------
    logic [31:0] perf_stall_reg, perf_empty_reg, perf_redir_reg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perf_stall_reg <= '0;
            perf_empty_reg <= '0;
            perf_redir_reg <= '0;
        end else begin
            if (instr_valid && stall && (perf_stall_reg != '1)) begin
                perf_stall_reg <= perf_stall_reg + 32'd1;
            end
            if (!instr_valid && (state_reg == FETCH) && (perf_empty_reg != '1)) begin
                perf_empty_reg <= perf_empty_reg + 32'd1;
            end
            if (redirect && (perf_redir_reg != '1)) begin
                perf_redir_reg <= perf_redir_reg + 32'd1;
            end
        end
    end

    assign perf_stall_cycles = perf_stall_reg;
    assign perf_empty_cycles = perf_empty_reg;
    assign perf_redirects    = perf_redir_reg;
`endif

endmodule

// File: tb/tb_if_prefetch_queue.sv
// ============================================================================
// tb_if_prefetch_queue
// Directed bench for if_prefetch_queue. A cycle table covers streaming,
// stall fill, redirect and redirect+stall. Hand-written sequences cover a
// redirect with two requests in flight, request backpressure and an
// asynchronous reset during a flush. The memory model returns
// addr[31:0] ^ KEY after a programmable latency.
// ============================================================================
module tb_if_prefetch_queue;

    localparam logic [31:0] KEY = 32'h1234_5678;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b1;
    logic [63:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect = 1'b0;
    logic [63:0] redirect_pc = 64'h0;
    logic        stall = 1'b0;
    logic        instr_valid;
    logic [31:0] instr;
    logic [63:0] instr_pc;
    logic [2:0]  occupancy;

    always #5 clk = ~clk;

    if_prefetch_queue #(.DEPTH(4), .RESET_PC(64'h0)) dut (
        .clk            (clk),
        .reset          (reset),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect       (redirect),
        .redirect_pc    (redirect_pc),
        .stall          (stall),
        .instr_valid    (instr_valid),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .occupancy      (occupancy)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end else begin
            $display("ok   %s = %h", name, act);
        end
    endtask

    // ------------------------------------------------------------------
    // Instruction memory model: in order, fixed latency, dropped on reset.
    // A request accepted at edge k is answered during cycle k-1+mem_lat.
    // ------------------------------------------------------------------
    typedef struct {
        int          due;
        logic [63:0] addr;
    } mreq_t;

    mreq_t       mq[$];
    logic [63:0] accepted[$];
    int          mem_lat = 1;
    int          mcyc = 0;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            mq.delete();
            accepted.delete();
            mcyc = 0;
            imem_rsp_valid <= 1'b0;
            imem_rsp_data  <= 32'h0;
        end else begin
            mcyc = mcyc + 1;
            if (imem_req_valid && imem_req_ready) begin
                mq.push_back('{due: mcyc - 1 + mem_lat, addr: imem_req_addr});
                accepted.push_back(imem_req_addr);
            end
            if (mq.size() > 0 && mq[0].due == mcyc) begin
                imem_rsp_valid <= 1'b1;
                imem_rsp_data  <= mq[0].addr[31:0] ^ KEY;
                void'(mq.pop_front());
            end else begin
                imem_rsp_valid <= 1'b0;
            end
        end
    end

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Hold reset for two edges, release mid-cycle. The next tick() lands in
    // cycle 1, the first FETCH cycle.
    task automatic do_reset(input int lat);
        reset = 1'b0;
        redirect = 1'b0;
        stall = 1'b0;
        imem_req_ready = 1'b1;
        mem_lat = lat;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    // ------------------------------------------------------------------
    // Cycle table, 1-cycle memory, req_ready=1; entry i is cycle i+1.
    // ------------------------------------------------------------------
    typedef struct {
        logic        st;
        logic        rd;
        logic [63:0] rpc;
        logic        e_valid;
        logic [63:0] e_pc;
        logic [2:0]  e_occ;
        logic        e_reqv;
        logic [63:0] e_addr;
    } vec_t;

    localparam int NV = 21;
    vec_t vt[NV];

    task automatic set_vec(input int i, input logic st, input logic rd, input logic [63:0] rpc,
                           input logic v, input logic [63:0] pc, input logic [2:0] occ,
                           input logic rq, input logic [63:0] addr);
        vt[i] = '{st: st, rd: rd, rpc: rpc, e_valid: v, e_pc: pc, e_occ: occ,
                  e_reqv: rq, e_addr: addr};
    endtask

    // Sequence up to the redirect cycle (cycle 10) with 3-cycle memory:
    // the head is 0x10, three requests are out and one response arrives,
    // so two responses remain to be discarded.
    task automatic run_to_redirect();
        do_reset(3);
        for (int c = 1; c <= 9; c++) begin
            tick();
        end
        tick();
        chk("rd2.c10_valid", {63'h0, instr_valid}, 64'h1);
        chk("rd2.c10_pc", instr_pc, 64'h10);
        redirect = 1'b1;
        redirect_pc = 64'h400;
        #1;
        chk("rd2.c10_reqv", {63'h0, imem_req_valid}, 64'h0);
    endtask

    logic        prev_vr;
    logic [63:0] prev_addr;
    logic [63:0] popped[$];

    initial begin
        // ---------------- reset values ----------------
        reset = 1'b0;
        #3;
        chk("rst.reqv", {63'h0, imem_req_valid}, 64'h0);
        chk("rst.valid", {63'h0, instr_valid}, 64'h0);
        chk("rst.instr", {32'h0, instr}, 64'h0);
        chk("rst.pc", instr_pc, 64'h0);
        chk("rst.occ", {61'h0, occupancy}, 64'h0);

        // ---------------- table-driven vectors ----------------
        //          i  st rd rpc      v  pc      occ rq addr
        set_vec( 0, 0, 0, 64'h0,   0, 64'h0,   0, 1, 64'h0);
        set_vec( 1, 0, 0, 64'h0,   0, 64'h0,   0, 1, 64'h4);
        set_vec( 2, 0, 0, 64'h0,   1, 64'h0,   1, 1, 64'h8);
        set_vec( 3, 0, 0, 64'h0,   1, 64'h4,   1, 1, 64'hC);
        set_vec( 4, 1, 0, 64'h0,   1, 64'h8,   1, 1, 64'h10);
        set_vec( 5, 1, 0, 64'h0,   1, 64'h8,   2, 1, 64'h14);
        set_vec( 6, 1, 0, 64'h0,   1, 64'h8,   3, 0, 64'h18);
        set_vec( 7, 1, 0, 64'h0,   1, 64'h8,   4, 0, 64'h18);
        set_vec( 8, 0, 0, 64'h0,   1, 64'h8,   4, 0, 64'h18);
        set_vec( 9, 0, 0, 64'h0,   1, 64'hC,   3, 1, 64'h18);
        set_vec(10, 0, 0, 64'h0,   1, 64'h10,  2, 1, 64'h1C);
        set_vec(11, 0, 0, 64'h0,   1, 64'h14,  2, 1, 64'h20);
        set_vec(12, 0, 1, 64'h400, 1, 64'h18,  2, 0, 64'h24);
        set_vec(13, 0, 0, 64'h0,   0, 64'h18,  0, 1, 64'h400);
        set_vec(14, 0, 0, 64'h0,   0, 64'h18,  0, 1, 64'h404);
        set_vec(15, 1, 0, 64'h0,   1, 64'h400, 1, 1, 64'h408);
        set_vec(16, 1, 0, 64'h0,   1, 64'h400, 2, 1, 64'h40C);
        set_vec(17, 1, 1, 64'h800, 1, 64'h400, 3, 0, 64'h410);
        set_vec(18, 0, 0, 64'h0,   0, 64'h400, 0, 1, 64'h800);
        set_vec(19, 0, 0, 64'h0,   0, 64'h400, 0, 1, 64'h804);
        set_vec(20, 0, 0, 64'h0,   1, 64'h800, 1, 1, 64'h808);

        do_reset(1);
        for (int i = 0; i < NV; i++) begin
            tick();
            stall = vt[i].st;
            redirect = vt[i].rd;
            redirect_pc = vt[i].rpc;
            #1;
            chk($sformatf("vec%0d.valid", i + 1), {63'h0, instr_valid}, {63'h0, vt[i].e_valid});
            chk($sformatf("vec%0d.pc", i + 1), instr_pc, vt[i].e_pc);
            chk($sformatf("vec%0d.occ", i + 1), {61'h0, occupancy}, {61'h0, vt[i].e_occ});
            chk($sformatf("vec%0d.reqv", i + 1), {63'h0, imem_req_valid}, {63'h0, vt[i].e_reqv});
            chk($sformatf("vec%0d.addr", i + 1), imem_req_addr, vt[i].e_addr);
            if (vt[i].e_valid) begin
                chk($sformatf("vec%0d.instr", i + 1), {32'h0, instr}, {32'h0, vt[i].e_pc[31:0] ^ KEY});
            end
        end

        // ---------------- redirect with two in flight ----------------
        run_to_redirect();
        for (int c = 11; c <= 17; c++) begin
            tick();
            redirect = 1'b0;
            #1;
            if (c <= 12) begin
                chk($sformatf("rd2.c%0d_reqv", c), {63'h0, imem_req_valid}, 64'h0);
            end
            if (c == 13) begin
                chk("rd2.c13_reqv", {63'h0, imem_req_valid}, 64'h1);
                chk("rd2.c13_addr", imem_req_addr, 64'h400);
            end
            if (c < 17) begin
                chk($sformatf("rd2.c%0d_valid", c), {63'h0, instr_valid}, 64'h0);
            end else begin
                chk("rd2.c17_valid", {63'h0, instr_valid}, 64'h1);
                chk("rd2.c17_pc", instr_pc, 64'h400);
                chk("rd2.c17_instr", {32'h0, instr}, {32'h0, 32'h400 ^ KEY});
            end
        end

        // ---------------- backpressure 1010... ----------------
        do_reset(1);
        popped.delete();
        prev_vr = 1'b0;
        prev_addr = 64'h0;
        for (int c = 1; c <= 40; c++) begin
            tick();
            imem_req_ready = (c % 2 == 1);
            #1;
            if (prev_vr) begin
                chk($sformatf("bp.c%0d_hold_valid", c), {63'h0, imem_req_valid}, 64'h1);
                chk($sformatf("bp.c%0d_hold_addr", c), imem_req_addr, prev_addr);
            end
            prev_vr = imem_req_valid && !imem_req_ready;
            prev_addr = imem_req_addr;
            if (instr_valid) begin
                popped.push_back(instr_pc);
            end
        end
        imem_req_ready = 1'b1;
        chk("bp.n_accepted_ge15", {63'h0, accepted.size() >= 15}, 64'h1);
        chk("bp.n_popped_ge10", {63'h0, popped.size() >= 10}, 64'h1);
        for (int k = 0; k < accepted.size(); k++) begin
            chk($sformatf("bp.fetch%0d", k), accepted[k], 64'(4 * k));
        end
        for (int k = 0; k < popped.size(); k++) begin
            chk($sformatf("bp.pop%0d", k), popped[k], 64'(4 * k));
        end

        // ---------------- async reset mid-flush ----------------
        run_to_redirect();
        tick();
        redirect = 1'b0;
        #1;
        chk("arst.pre_pc", instr_pc, 64'h10);
        reset = 1'b0;
        #1;
        chk("arst.reqv", {63'h0, imem_req_valid}, 64'h0);
        chk("arst.valid", {63'h0, instr_valid}, 64'h0);
        chk("arst.instr", {32'h0, instr}, 64'h0);
        chk("arst.pc", instr_pc, 64'h0);
        chk("arst.occ", {61'h0, occupancy}, 64'h0);
        do_reset(1);
        tick();
        #1;
        chk("arst.c1_reqv", {63'h0, imem_req_valid}, 64'h1);
        chk("arst.c1_addr", imem_req_addr, 64'h0);
        tick();
        #1;
        chk("arst.c2_addr", imem_req_addr, 64'h4);
        tick();
        #1;
        chk("arst.c3_valid", {63'h0, instr_valid}, 64'h1);
        chk("arst.c3_pc", instr_pc, 64'h0);

        // ---------------- overflow flag never set ----------------
        chk("ovf", {63'h0, dut.ovf_reg}, 64'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1, "watchdog");
    end

endmodule
